// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
package bus_sched_pkg;

   localparam int unsigned     ID_W          = 8;
   localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;
   localparam int unsigned     PKT_MAX_W     = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      PUSH = 2'd2
   } state_e;

   // Destination ID lives in the top ID_W bits of a packet of width sz.
   function automatic logic [ID_W-1:0] pkt_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned           sz);
      logic [PKT_MAX_W-1:0] sh;
      sh = pkt >> (sz - ID_W);
      return sh[ID_W-1:0];
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after `last`,
// wrapping at N, built as rotate / priority-encode / un-rotate.
module rr_picker
   import bus_sched_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic            any,
   output logic [ID_W-1:0] idx
);

   logic [2*N-1:0] dbl_s;
   logic [2*N-1:0] shifted_s;
   logic [N-1:0]   rot_s;
   int unsigned    start_s;
   int unsigned    enc_s;
   int unsigned    sum_s;

   // Rotate so the search origin sits at bit 0, encode, then rotate back.
   always_comb begin
      if ((32'(last) + 32'd1) >= N) begin
         start_s = 32'd0;
      end else begin
         start_s = 32'(last) + 32'd1;
      end
      dbl_s     = {req, req};
      shifted_s = dbl_s >> start_s;
      rot_s     = shifted_s[N-1:0];
      enc_s     = 32'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            enc_s = unsigned'(i);
         end else begin
            enc_s = enc_s;
         end
      end
      sum_s = enc_s + start_s;
      if (sum_s >= N) begin
         sum_s = sum_s - N;
      end else begin
         sum_s = sum_s;
      end
      any = |req;
      idx = ID_W'(sum_s);
   end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler sharing one packet bus between driver FIFOs.
// Each packet passes IDLE (grant), POP (dequeue) and PUSH (deliver).
module bus_rr_scheduler
   import bus_sched_pkg::*;
#(
   parameter int unsigned     pckg_sz   = 16,
   parameter int unsigned     drvrs     = 8,
   parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [drvrs-1:0]              pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0] D_pop,
   output logic [drvrs-1:0]              pop,
   output logic [drvrs-1:0]              push,
   output logic [pckg_sz-1:0]            D_push,
   output logic [ID_W-1:0]               gnt_id,
   output logic                          busy,
   output logic [15:0]                   pkt_cnt,
   output logic [15:0]                   drop_cnt
);

   localparam logic [ID_W-1:0] LAST_RST = ID_W'(drvrs - 1);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    gnt_q, gnt_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [pckg_sz-1:0] pkt_q, pkt_d;
   logic [pckg_sz-1:0] d_push_q, d_push_d;
   logic [drvrs-1:0]   pop_q, pop_d;
   logic [drvrs-1:0]   push_q, push_d;
   logic               busy_q, busy_d;
   logic [15:0]        pkt_cnt_q, pkt_cnt_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;

   logic               pick_any_s;
   logic [ID_W-1:0]    pick_idx_s;
   logic [drvrs-1:0]   gnt_oh_s;
   logic [drvrs-1:0]   dest_oh_s;
   logic               gnt_pnd_s;
   logic [pckg_sz-1:0] gnt_data_s;
   logic [ID_W-1:0]    dest_s;
   logic               dest_ok_s;

   rr_picker #(.N(drvrs)) u_picker (
      .req  (pndng),
      .last (last_q),
      .any  (pick_any_s),
      .idx  (pick_idx_s)
   );

   // Decode the granted source and the held packet's destination to one-hot form.
   always_comb begin
      gnt_pnd_s  = 1'b0;
      gnt_data_s = '0;
      dest_s     = pkt_dest(PKT_MAX_W'(pkt_q), pckg_sz);
      for (int i = 0; i < drvrs; i++) begin
         gnt_oh_s[i]  = (ID_W'(i) == gnt_q);
         dest_oh_s[i] = (ID_W'(i) == dest_s);
         gnt_pnd_s    = gnt_pnd_s | (pndng[i] & gnt_oh_s[i]);
         gnt_data_s   = gnt_data_s | (D_pop[i] & {pckg_sz{gnt_oh_s[i]}});
      end
      dest_ok_s = (32'(dest_s) < drvrs) && (dest_s != gnt_q);
   end

   // Next-state and next-output logic; strobes default low so they last one cycle.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      pkt_d      = pkt_q;
      pop_d      = '0;
      push_d     = '0;
      d_push_d   = '0;
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_any_s) begin
               gnt_d   = pick_idx_s;
               state_d = POP;
            end else begin
               state_d = IDLE;
            end
         end
         POP: begin
            // A source that withdrew its request is skipped without touching `last`.
            if (gnt_pnd_s) begin
               pop_d   = gnt_oh_s;
               pkt_d   = gnt_data_s;
               last_d  = gnt_q;
               state_d = PUSH;
            end else begin
               state_d = IDLE;
            end
         end
         PUSH: begin
            d_push_d = pkt_q;
            if (dest_s == broadcast) begin
               push_d    = ~gnt_oh_s;
               pkt_cnt_d = sat_inc(pkt_cnt_q);
            end else if (dest_ok_s) begin
               push_d    = dest_oh_s;
               pkt_cnt_d = sat_inc(pkt_cnt_q);
            end else begin
               drop_cnt_d = sat_inc(drop_cnt_q);
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset discards any packet in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         last_q     <= LAST_RST;
         pkt_q      <= '0;
         pop_q      <= '0;
         push_q     <= '0;
         d_push_q   <= '0;
         busy_q     <= 1'b0;
         pkt_cnt_q  <= 16'd0;
         drop_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         pkt_q      <= pkt_d;
         pop_q      <= pop_d;
         push_q     <= push_d;
         d_push_q   <= d_push_d;
         busy_q     <= busy_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign pop      = pop_q;
   assign push     = push_q;
   assign D_push   = d_push_q;
   assign gnt_id   = gnt_q;
   assign busy     = busy_q;
   assign pkt_cnt  = pkt_cnt_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Randomized bench for bus_rr_scheduler against a queue-based transaction model.
module tb_bus_rr_scheduler;

   localparam int N = 8;
   localparam int W = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic [N-1:0]        pndng;
   logic [N-1:0][W-1:0] D_pop;
   logic [N-1:0]        pop;
   logic [N-1:0]        push;
   logic [W-1:0]        D_push;
   logic [7:0]          gnt_id;
   logic                busy;
   logic [15:0]         pkt_cnt;
   logic [15:0]         drop_cnt;

   always #5 clk = ~clk;

   bus_rr_scheduler #(.pckg_sz(W), .drvrs(N), .broadcast(8'hFF)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push), .gnt_id(gnt_id), .busy(busy),
      .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   logic [W-1:0] q[N][$];
   int           pop_log[$];
   logic [N-1:0] mask;
   logic [N-1:0] drv_prev, drv_prev2;
   int           cyc, n_chk, n_fail;
   int           m_last, m_pkt, m_drop;
   logic         exp_valid, pop_seen;
   logic [N-1:0] exp_push;
   logic [W-1:0] exp_data;
   int           last_pop_cyc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int model_pick(input logic [N-1:0] pend);
      for (int k = 1; k <= N; k++) begin
         if (pend[(m_last + k) % N]) return (m_last + k) % N;
      end
      return -1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         pndng[i] = (q[i].size() > 0) && !mask[i];
         D_pop[i] = (q[i].size() > 0) ? q[i][0] : '0;
      end
   endtask

   // One clock: sample at negedge, check against the model, then re-drive inputs.
   task automatic step();
      int           src;
      logic [W-1:0] pkt;
      logic [7:0]   dest;
      @(negedge clk);
      cyc++;
      pop_seen = 1'b0;
      check_eq("pop_push_overlap", 32'((pop != 0) && (push != 0)), 32'd0);
      if (exp_valid) begin
         check_eq("push_vec", 32'(push), 32'(exp_push));
         if (exp_push != 0) check_eq("d_push", 32'(D_push), 32'(exp_data));
         check_eq("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
         check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
         exp_valid = 1'b0;
      end else begin
         check_eq("push_idle", 32'(push), 32'd0);
      end
      if (pop != 0) begin
         pop_seen = 1'b1;
         src = model_pick(drv_prev2);
         check_eq("grant_exists", 32'(src >= 0), 32'd1);
         if (src >= 0) begin
            check_eq("pop_vec", 32'(pop), 32'd1 << src);
            check_eq("gnt_id", 32'(gnt_id), 32'(src));
            check_eq("busy_pop", 32'(busy), 32'd1);
            pkt  = q[src].pop_front();
            dest = pkt[W-1 -: 8];
            m_last = src;
            pop_log.push_back(src);
            last_pop_cyc = cyc;
            exp_data = pkt;
            if (dest == 8'hFF) begin
               exp_push = ~(N'(1) << src);
               if (m_pkt < 65535) m_pkt++;
            end else if (int'(dest) < N && int'(dest) != src) begin
               exp_push = N'(1) << dest;
               if (m_pkt < 65535) m_pkt++;
            end else begin
               exp_push = '0;
               if (m_drop < 65535) m_drop++;
            end
            exp_valid = 1'b1;
         end
      end
      drv_prev2 = drv_prev;
      drive_inputs();
      drv_prev = pndng;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_until_idle(input int budget);
      int n = 0;
      while ((!all_empty() || exp_valid) && n < budget) begin
         step();
         n++;
      end
      check_eq("drain_timeout", 32'(n >= budget), 32'd0);
      step();
      step();
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) q[i].delete();
      mask = '0; exp_valid = 1'b0; m_last = N - 1; m_pkt = 0; m_drop = 0;
   endtask

   initial begin
      int start, tries;
      int src, r;
      logic [7:0] dest;
      n_chk = 0; n_fail = 0; cyc = 0;
      reset = 1'b0; pndng = '0; D_pop = '0; drv_prev = '0; drv_prev2 = '0;
      model_reset();
      step(); step();
      check_eq("rst_pop", 32'(pop), 32'd0);
      check_eq("rst_gnt_id", 32'(gnt_id), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check_eq("rst_d_push", 32'(D_push), 32'd0);
      reset = 1'b1;
      step();

      // Single unicast packet: latency and delivery.
      q[0].push_back(16'h0355);
      start = cyc;
      run_until_idle(20);
      check_eq("t1_pop_latency", 32'(last_pop_cyc - start), 32'd3);
      check_eq("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

      // Broadcast from source 2.
      q[2].push_back(16'hFF12);
      run_until_idle(20);
      check_eq("t3_pkt_cnt", 32'(pkt_cnt), 32'd2);

      // Abort: source 3 withdraws during POP.
      q[3].push_back(16'h01A5);
      step();
      mask[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("abort_no_pop", 32'(pop), 32'd0);
      end
      mask = '0;
      q[4].push_back(16'h0912);
      q[5].push_back(16'h0577);
      pop_log.delete();
      run_until_idle(40);
      check_eq("abort_regrant_3", 32'(pop_log.size() > 0 ? pop_log[0] : -1), 32'd3);
      check_eq("t4_drop_cnt", 32'(drop_cnt), 32'd2);
      check_eq("t4_pkt_cnt", 32'(pkt_cnt), 32'd3);

      // Reset pulsed while a packet sits in PUSH.
      q[0].push_back(16'h01C3);
      tries = 0;
      pop_seen = 1'b0;
      while (!pop_seen && tries < 10) begin
         step();
         tries++;
      end
      check_eq("rp_pop_seen", 32'(pop_seen), 32'd1);
      reset = 1'b0;
      #1;
      check_eq("rp_push", 32'(push), 32'd0);
      check_eq("rp_pkt_cnt", 32'(pkt_cnt), 32'd0);
      check_eq("rp_drop_cnt", 32'(drop_cnt), 32'd0);
      check_eq("rp_busy", 32'(busy), 32'd0);
      model_reset();
      step(); step();
      reset = 1'b1;

      // All sources pending, each to (src+1)%8: strict 0..7 rotation.
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 3; k++)
            q[i].push_back({8'((i + 1) % N), 8'($urandom_range(0, 255))});
      pop_log.delete();
      run_until_idle(200);
      check_eq("rr_count", 32'(pop_log.size()), 32'd24);
      for (int k = 0; k < 24 && k < pop_log.size(); k++)
         check_eq("rr_order", 32'(pop_log[k]), 32'(k % N));

      // Random arrivals with unicast, broadcast, self-route and invalid destinations.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            src = $urandom_range(0, N - 1);
            r   = $urandom_range(0, 9);
            if (r == 0)      dest = 8'hFF;
            else if (r == 1) dest = 8'(src);
            else if (r == 2) dest = 8'($urandom_range(N, 254));
            else             dest = 8'($urandom_range(0, N - 1));
            q[src].push_back({dest, 8'($urandom_range(0, 255))});
         end
         step();
      end
      run_until_idle(2000);
      check_eq("final_pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
      check_eq("final_drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check_eq("final_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
- Round-robin scheduler that shares one packet bus between `drvrs` driver FIFOs.
- Grants one pending source, pops its head packet and decodes the destination ID from the packet MSBs.
- Pushes the packet to the destination FIFO, or to all other FIFOs on broadcast.
- Standalone controller alternative to the bs_gnrtr_n_rbtr bus, pin-compatible on pndng/push/pop/D_pop/D_push so the existing FIFO interface bench can drive it.

Parameters:
- pckg_sz, 16, packet width in bits; ID field is pckg_sz[pckg_sz-1 -: 8].
- drvrs, 8, number of driver ports (2..255).
- broadcast, 8'hFF, destination ID meaning "all drivers except source".

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  [drvrs-1:0]  FIFO i holds at least one packet.
- D_pop  in  [drvrs-1:0][pckg_sz-1:0]  head-of-FIFO data, valid while pndng[i]=1.
- pop  out  [drvrs-1:0]  one-cycle dequeue strobe to FIFO i.
- push  out  [drvrs-1:0]  one-cycle enqueue strobe to FIFO i.
- D_push  out  [pckg_sz-1:0]  shared bus data, valid when any push bit is 1.
- gnt_id  out  [7:0]  index of the currently or last granted source.
- busy  out  1  high in any state other than IDLE.
- pkt_cnt  out  [15:0]  delivered packets, saturating.
- drop_cnt  out  [15:0]  dropped packets, saturating.

Behaviour:
- Reset (async assert, sync release):
  - pop=0, push=0, D_push=0, gnt_id=0, busy=0, pkt_cnt=0, drop_cnt=0.
  - State=IDLE; last-grant pointer=drvrs-1, so driver 0 has highest priority first.
- All outputs are registered.
- States: IDLE -> POP -> PUSH -> IDLE. Per-packet latency is 3 cycles; maximum throughput is one packet per 3 cycles.
- IDLE:
  - If pndng==0, stay.
  - Otherwise pick the first set bit of pndng searching upward from last+1, wrapping at drvrs. Register it as gnt, drive gnt_id, go to POP.
- POP:
  - If pndng[gnt]==1: pop[gnt]=1 for exactly this cycle, pkt<=D_pop[gnt], last<=gnt, go to PUSH.
  - If pndng[gnt] has dropped (abort): no pop, last unchanged, go to IDLE.
- PUSH: dest=pkt[pckg_sz-1 -: 8]. D_push=pkt for this cycle.
  - dest==broadcast: push = all ones with push[gnt]=0; pkt_cnt+1.
  - dest<drvrs and dest!=gnt: push[dest]=1; pkt_cnt+1.
  - dest==gnt (self-route) or dest>=drvrs (invalid): push=0; drop_cnt+1.
  - Always return to IDLE.
- pop and push are never asserted in the same cycle. At most one pop bit is set at any time.
- Counters saturate at 16'hFFFF.
- Fairness: any source with pndng held high is granted within drvrs grants.
- Reset asserted mid-packet: the packet is discarded, its pop may already have occurred, and no push follows.
- gnt_id holds its value through IDLE after the packet completes.

Decomposition:
- Package bus_sched_pkg: state enum {IDLE, POP, PUSH}, ID_W=8, BCAST_DEFAULT=8'hFF, and a function extracting the dest field.
- Sub-module rr_picker (combinational): inputs req[drvrs-1:0] and last; outputs any and idx. Uses a rotate / priority-encode / un-rotate structure.

Test Plan:
- After reset, pndng=8'b0000_0001, D_pop[0]=16'h0355 -> pop[0] on cycle 1, push=8'b0000_1000 with D_push=16'h0355 on cycle 2; pkt_cnt=1.
- pndng=8'hFF held for 24 cycles, each packet addressed to (src+1)%8 -> grants 0,1,...,7 in order, each exactly once; pop never overlaps push.
- Broadcast: D_pop[2]=16'hFF12 from source 2 -> push=8'b1111_1011, D_push=16'hFF12.
- Invalid dest 8'h09 from source 4, then self-route 8'h05 from source 5 -> push stays 0 in both PUSH cycles; drop_cnt=2; pkt_cnt unchanged.
- Abort and reset cases:
  - pndng[3] dropped to 0 in the POP cycle -> no pop[3]; the next grant search still starts at 3.
  - reset pulsed low during PUSH -> push=0 immediately and all counters 0.
